// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings and decode enums for the
// single-cycle MIPS-subset core.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] F_SLL  = 6'd0;
    localparam logic [5:0] F_MFHI = 6'd16;
    localparam logic [5:0] F_MFLO = 6'd18;
    localparam logic [5:0] F_DIVU = 6'd27;
    localparam logic [5:0] F_ADD  = 6'd32;
    localparam logic [5:0] F_SUB  = 6'd34;
    localparam logic [5:0] F_AND  = 6'd36;
    localparam logic [5:0] F_OR   = 6'd37;
    localparam logic [5:0] F_SLT  = 6'd42;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL
    } alu_op_t;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_HI,
        WB_LO
    } wb_sel_t;

endpackage

// File: rtl/mips_single_byte_mem.sv
// Little-endian byte-array memory: combinational word read,
// synchronous word write, addresses wrap modulo size.
module byte_mem #(
    parameter int BYTES = 128
) (
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(BYTES);

    logic [7:0]    mem_array [0:BYTES-1];
    logic [AW-1:0] a0, a1, a2, a3;
    logic          unused_hi;

    assign a0 = addr[AW-1:0];
    assign a1 = a0 + AW'(1);
    assign a2 = a0 + AW'(2);
    assign a3 = a0 + AW'(3);
    assign unused_hi = ^addr[31:AW];

    assign rdata = {mem_array[a3], mem_array[a2],
                    mem_array[a1], mem_array[a0]};

    // Commit all four bytes of a word store on the clock edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_array[a0] <= wdata[7:0];
            mem_array[a1] <= wdata[15:8];
            mem_array[a2] <= wdata[23:16];
            mem_array[a3] <= wdata[31:24];
        end
    end

endmodule

// File: rtl/mips_single_reg_file.sv
// 32x32 register file: two combinational reads, one synchronous
// write; register 0 is hard-wired to zero.
module reg_file (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] file_array [0:31];

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : file_array[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : file_array[ra2];

    // Write port; writes aimed at $0 are dropped.
    always_ff @(posedge clk) begin
        if (we && wa != 5'd0)
            file_array[wa] <= wd;
    end

endmodule

// File: rtl/mips_single.sv
// Single-cycle MIPS-subset CPU top: fetch, inline decode and ALU,
// register file, data memory and HI/LO, one instruction per clock.
module mips_single
    import mips_pkg::*;
#(
    parameter int IMEM_BYTES = 128,
    parameter int DMEM_BYTES = 128
) (
    input logic clk,
    input logic rst
);
    logic [31:0] pc, pc_next, pc_plus4, br_target;
    logic [31:0] instr2, rfile_wd;
    logic [31:0] rd1, rd2, imm_ext, alu_b, alu_y, mem_rd;
    logic [31:0] hi, lo;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt, dst;
    logic [15:0] imm;
    alu_op_t     alu_op;
    wb_sel_t     wb_sel;
    logic        use_imm, zext, reg_we, mem_we;
    logic        is_beq, is_bne, is_j, is_divu, take;

    assign opcode = instr2[31:26];
    assign rs     = instr2[25:21];
    assign rt     = instr2[20:16];
    assign rd     = instr2[15:11];
    assign shamt  = instr2[10:6];
    assign funct  = instr2[5:0];
    assign imm    = instr2[15:0];

    byte_mem #(.BYTES(IMEM_BYTES)) InstrMem (
        .clk   (clk),
        .we    (1'b0),
        .addr  (pc),
        .wdata (32'd0),
        .rdata (instr2)
    );

    // Decode: default is a no-effect instruction.
    always_comb begin
        alu_op  = ALU_ADD;
        wb_sel  = WB_ALU;
        dst     = rd;
        use_imm = 1'b0;
        zext    = 1'b0;
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_j    = 1'b0;
        is_divu = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_ADD:  reg_we = 1'b1;
                    F_SUB:  begin alu_op = ALU_SUB; reg_we = 1'b1; end
                    F_AND:  begin alu_op = ALU_AND; reg_we = 1'b1; end
                    F_OR:   begin alu_op = ALU_OR;  reg_we = 1'b1; end
                    F_SLT:  begin alu_op = ALU_SLT; reg_we = 1'b1; end
                    F_SLL:  begin alu_op = ALU_SLL; reg_we = 1'b1; end
                    F_DIVU: is_divu = 1'b1;
                    F_MFHI: begin wb_sel = WB_HI; reg_we = 1'b1; end
                    F_MFLO: begin wb_sel = WB_LO; reg_we = 1'b1; end
                    default: ;
                endcase
            end
            OP_LW: begin
                use_imm = 1'b1;
                reg_we  = 1'b1;
                dst     = rt;
                wb_sel  = WB_MEM;
            end
            OP_SW: begin
                use_imm = 1'b1;
                mem_we  = 1'b1;
            end
            OP_ORI: begin
                alu_op  = ALU_OR;
                use_imm = 1'b1;
                zext    = 1'b1;
                reg_we  = 1'b1;
                dst     = rt;
            end
            OP_BEQ:  is_beq = 1'b1;
            OP_BNE:  is_bne = 1'b1;
            OP_J:    is_j   = 1'b1;
            default: ;
        endcase
    end

    reg_file RegFile (
        .clk (clk),
        .we  (reg_we & ~rst),
        .ra1 (rs),
        .ra2 (rt),
        .wa  (dst),
        .wd  (rfile_wd),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    assign imm_ext = zext ? {16'd0, imm} : {{16{imm[15]}}, imm};
    assign alu_b   = use_imm ? imm_ext : rd2;

    // ALU: wrap-around arithmetic, signed compare, left shift of rt.
    always_comb begin
        alu_y = 32'd0;
        case (alu_op)
            ALU_ADD: alu_y = rd1 + alu_b;
            ALU_SUB: alu_y = rd1 - alu_b;
            ALU_AND: alu_y = rd1 & alu_b;
            ALU_OR:  alu_y = rd1 | alu_b;
            ALU_SLT: alu_y = {31'd0, $signed(rd1) < $signed(alu_b)};
            ALU_SLL: alu_y = rd2 << shamt;
            default: alu_y = 32'd0;
        endcase
    end

    byte_mem #(.BYTES(DMEM_BYTES)) DatMem (
        .clk   (clk),
        .we    (mem_we & ~rst),
        .addr  (alu_y),
        .wdata (rd2),
        .rdata (mem_rd)
    );

    // Write-back select; zero whenever no register is written.
    always_comb begin
        rfile_wd = 32'd0;
        if (reg_we) begin
            case (wb_sel)
                WB_ALU:  rfile_wd = alu_y;
                WB_MEM:  rfile_wd = mem_rd;
                WB_HI:   rfile_wd = hi;
                WB_LO:   rfile_wd = lo;
                default: rfile_wd = 32'd0;
            endcase
        end
    end

    assign pc_plus4  = pc + 32'd4;
    assign br_target = pc_plus4 + {imm_ext[29:0], 2'b00};
    assign take      = (is_beq && rd1 == rd2) || (is_bne && rd1 != rd2);

    // Next-PC: jump, taken branch, or fall through.
    always_comb begin
        pc_next = pc_plus4;
        if (is_j)
            pc_next = {pc_plus4[31:28], instr2[25:0], 2'b00};
        else if (take)
            pc_next = br_target;
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst)
            pc <= 32'd0;
        else
            pc <= pc_next;
    end

    // HI/LO: unsigned divide result; divide by zero leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (is_divu && rd2 != 32'd0) begin
            lo <= rd1 / rd2;
            hi <= rd1 % rd2;
        end
    end

endmodule

// File: tb/tb_mips_single.sv
// Bench for mips_single: architectural reference model feeds a
// scoreboard of per-cycle pc/instr/write-data; final state compared.
module tb_mips_single;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mips_single #(.IMEM_BYTES(128), .DMEM_BYTES(128)) dut (
        .clk (clk),
        .rst (rst)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] wd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  m_imem [0:127];
    logic [7:0]  m_dmem [0:127];
    logic [31:0] m_regs [0:31];
    logic [31:0] m_pc, m_hi, m_lo;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic logic [31:0] rt_ins(int s, int t, int d, int sh, logic [5:0] fn);
        logic [4:0] s5, t5, d5, h5;
        s5 = 5'(s); t5 = 5'(t); d5 = 5'(d); h5 = 5'(sh);
        return {6'd0, s5, t5, d5, h5, fn};
    endfunction

    function automatic logic [31:0] i_ins(logic [5:0] op, int s, int t, int im);
        logic [4:0]  s5, t5;
        logic [15:0] i16;
        s5 = 5'(s); t5 = 5'(t); i16 = 16'(im);
        return {op, s5, t5, i16};
    endfunction

    function automatic logic [31:0] rd_word(ref logic [7:0] m [0:127], input logic [31:0] a);
        return {m[(a + 3) & 127], m[(a + 2) & 127], m[(a + 1) & 127], m[a & 127]};
    endfunction

    task automatic put(int idx, logic [31:0] w);
        for (int k = 0; k < 4; k++)
            m_imem[idx * 4 + k] = w[8 * k +: 8];
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 128; i++) m_imem[i] = 8'h00;
    endtask

    task automatic sync_dut();
        for (int i = 0; i < 128; i++) begin
            dut.InstrMem.mem_array[i] = m_imem[i];
            dut.DatMem.mem_array[i]   = m_dmem[i];
        end
        m_regs[0] = 32'd0;
        for (int i = 0; i < 32; i++) dut.RegFile.file_array[i] = m_regs[i];
    endtask

    task automatic start();
        rst = 1'b1;
        sync_dut();
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_pc = 0; m_hi = 0; m_lo = 0;
    endtask

    // Architectural step of the reference model; pushes expectation.
    task automatic step();
        logic [31:0] ins, a, b, se, ze, wd, npc, ad;
        logic [5:0]  op, fn;
        int          wr;
        exp_t        e;
        ins = rd_word(m_imem, m_pc);
        op  = ins[31:26];
        fn  = ins[5:0];
        a   = m_regs[ins[25:21]];
        b   = m_regs[ins[20:16]];
        se  = {{16{ins[15]}}, ins[15:0]};
        ze  = {16'd0, ins[15:0]};
        wd  = 0; wr = -1; npc = m_pc + 4;
        case (op)
            6'd0: case (fn)
                6'd32: begin wd = a + b; wr = int'(ins[15:11]); end
                6'd34: begin wd = a - b; wr = int'(ins[15:11]); end
                6'd36: begin wd = a & b; wr = int'(ins[15:11]); end
                6'd37: begin wd = a | b; wr = int'(ins[15:11]); end
                6'd42: begin wd = ($signed(a) < $signed(b)) ? 1 : 0; wr = int'(ins[15:11]); end
                6'd0:  begin wd = b << ins[10:6]; wr = int'(ins[15:11]); end
                6'd27: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
                6'd16: begin wd = m_hi; wr = int'(ins[15:11]); end
                6'd18: begin wd = m_lo; wr = int'(ins[15:11]); end
                default: ;
            endcase
            6'd35: begin ad = a + se; wd = rd_word(m_dmem, ad); wr = int'(ins[20:16]); end
            6'd43: begin
                ad = a + se;
                for (int k = 0; k < 4; k++) m_dmem[(ad + k) & 127] = b[8 * k +: 8];
            end
            6'd13: begin wd = a | ze; wr = int'(ins[20:16]); end
            6'd4:  if (a == b) npc = m_pc + 4 + se * 4;
            6'd5:  if (a != b) npc = m_pc + 4 + se * 4;
            6'd2:  npc = {npc[31:28], ins[25:0], 2'b00};
            default: ;
        endcase
        e.pc = m_pc; e.ins = ins; e.wd = wd;
        sb.push_back(e);
        if (wr > 0) m_regs[wr] = wd;
        m_pc = npc;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) begin
            step();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cmp_state();
        for (int r = 0; r < 32; r++)
            chk($sformatf("reg%0d", r), dut.RegFile.file_array[r], m_regs[r]);
        for (int w = 0; w < 32; w++)
            chk($sformatf("dmem%0d", w * 4),
                {dut.DatMem.mem_array[w * 4 + 3], dut.DatMem.mem_array[w * 4 + 2],
                 dut.DatMem.mem_array[w * 4 + 1], dut.DatMem.mem_array[w * 4]},
                rd_word(m_dmem, w * 4));
    endtask

    // Monitor: every executing cycle is compared to the next expectation.
    always @(negedge clk) begin
        if (!rst && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("pc", dut.pc, e.pc);
            chk("instr2", dut.instr2, e.ins);
            chk("rfile_wd", dut.rfile_wd, e.wd);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        clear_prog();
        for (int i = 0; i < 128; i++) m_dmem[i] = 8'h00;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;

        // ALU group
        m_regs[1] = 5; m_regs[2] = 3;
        put(0, rt_ins(1, 2, 3, 0, 6'd32));
        put(1, rt_ins(1, 2, 4, 0, 6'd34));
        put(2, rt_ins(1, 2, 5, 0, 6'd36));
        put(3, rt_ins(1, 2, 6, 0, 6'd37));
        put(4, rt_ins(2, 1, 7, 0, 6'd42));
        start();
        chk("reset_pc", dut.pc, 32'd0);
        chk("reset_hi", dut.hi, 32'd0);
        chk("reset_lo", dut.lo, 32'd0);
        run(5);
        chk("add", dut.RegFile.file_array[3], 32'd8);
        chk("sub", dut.RegFile.file_array[4], 32'd2);
        chk("and", dut.RegFile.file_array[5], 32'd1);
        chk("or", dut.RegFile.file_array[6], 32'd7);
        chk("slt", dut.RegFile.file_array[7], 32'd1);

        clear_prog();
        m_regs[1] = 32'hFFFF_FFFF; m_regs[7] = 0;
        put(0, rt_ins(1, 2, 7, 0, 6'd42));
        start();
        run(1);
        chk("slt_signed", dut.RegFile.file_array[7], 32'd1);

        // DIVU / MFHI / MFLO, then divide by zero
        clear_prog();
        m_regs[1] = 17; m_regs[2] = 5;
        put(0, rt_ins(1, 2, 0, 0, 6'd27));
        put(1, rt_ins(0, 0, 8, 0, 6'd16));
        put(2, rt_ins(0, 0, 9, 0, 6'd18));
        put(3, rt_ins(1, 0, 0, 0, 6'd27));
        put(4, rt_ins(0, 0, 13, 0, 6'd18));
        start();
        run(5);
        chk("mfhi", dut.RegFile.file_array[8], 32'd2);
        chk("mflo", dut.RegFile.file_array[9], 32'd3);
        chk("divu_zero", dut.RegFile.file_array[13], 32'd3);

        // Memory and ORI
        clear_prog();
        m_dmem[0] = 8'h78; m_dmem[1] = 8'h56; m_dmem[2] = 8'h34; m_dmem[3] = 8'h12;
        put(0, i_ins(6'd35, 0, 10, 0));
        put(1, i_ins(6'd43, 0, 10, 4));
        put(2, i_ins(6'd13, 0, 11, 16'hFFFF));
        start();
        run(3);
        chk("lw", dut.RegFile.file_array[10], 32'h1234_5678);
        chk("sw", {dut.DatMem.mem_array[7], dut.DatMem.mem_array[6],
                   dut.DatMem.mem_array[5], dut.DatMem.mem_array[4]}, 32'h1234_5678);
        chk("ori", dut.RegFile.file_array[11], 32'h0000_FFFF);

        // Branches: 0 -> 12 -> 16 -> J to 8 -> self-loop at 8
        clear_prog();
        m_regs[1] = 5;
        put(0, i_ins(6'd4, 1, 1, 2));
        put(3, i_ins(6'd5, 1, 1, 2));
        put(4, {6'd2, 26'd2});
        put(2, i_ins(6'd4, 0, 0, -1));
        start();
        run(6);
        chk("beq_loop_pc", dut.pc, 32'd8);

        // Jump at 0x20 back to 0x10, $0 write, SLL
        clear_prog();
        m_regs[1] = 5; m_regs[2] = 3; m_regs[12] = 0;
        put(4, rt_ins(1, 2, 0, 0, 6'd32));
        put(5, rt_ins(0, 1, 12, 2, 6'd0));
        put(8, {6'd2, 26'd4});
        start();
        run(12);
        chk("reg0", dut.RegFile.file_array[0], 32'd0);
        chk("sll", dut.RegFile.file_array[12], 32'd20);

        // Reset asserted while SW at 0x1C executes
        clear_prog();
        m_regs[1] = 17; m_regs[2] = 5;
        for (int k = 64; k < 68; k++) m_dmem[k] = 8'hAA;
        put(0, rt_ins(1, 2, 0, 0, 6'd27));
        put(7, i_ins(6'd43, 0, 1, 64));
        start();
        run(7);
        chk("pre_rst_pc", m_pc, dut.pc);
        chk("pre_rst_lo", dut.lo, 32'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_pc = 0; m_hi = 0; m_lo = 0;
        chk("midrst_pc", dut.pc, 32'd0);
        chk("midrst_hi", dut.hi, 32'd0);
        chk("midrst_lo", dut.lo, 32'd0);
        chk("midrst_mem", {dut.DatMem.mem_array[67], dut.DatMem.mem_array[66],
                           dut.DatMem.mem_array[65], dut.DatMem.mem_array[64]}, 32'hAAAA_AAAA);
        chk("midrst_reg", dut.RegFile.file_array[1], 32'd17);
        run(2);
        cmp_state();

        // Randomized programs against the reference model
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 128; i++) m_dmem[i] = 8'($urandom);
            for (int i = 1; i < 32; i++) m_regs[i] = (i < 4) ? 32'($urandom_range(0, 9)) : $urandom;
            for (int i = 0; i < 32; i++) begin
                int s, r, d, o;
                logic [31:0] w;
                s = $urandom_range(0, 31);
                r = $urandom_range(0, 31);
                d = $urandom_range(0, 31);
                o = int'($urandom_range(0, 6)) - 3;
                case ($urandom_range(0, 12))
                    0:  w = rt_ins(s, r, d, 0, 6'd32);
                    1:  w = rt_ins(s, r, d, 0, 6'd34);
                    2:  w = rt_ins(s, r, d, 0, 6'd36);
                    3:  w = rt_ins(s, r, d, 0, 6'd37);
                    4:  w = rt_ins(s, r, d, 0, 6'd42);
                    5:  w = rt_ins(0, r, d, $urandom_range(0, 31), 6'd0);
                    6:  w = rt_ins(s, r, 0, 0, 6'd27);
                    7:  w = rt_ins(0, 0, d, 0, ($urandom_range(0, 1) != 0) ? 6'd16 : 6'd18);
                    8:  w = i_ins(6'd35, s, r, $urandom_range(0, 65535));
                    9:  w = i_ins(6'd43, s, r, $urandom_range(0, 65535));
                    10: w = i_ins(6'd13, s, r, $urandom_range(0, 65535));
                    11: w = i_ins(6'd4, s % 4, r % 4, o);
                    default: w = i_ins(6'd5, s % 4, r % 4, o);
                endcase
                put(i, w);
            end
            start();
            run(60);
            cmp_state();
        end

        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
